// File: rtl/key_unwarm.sv
// Reverse AES-128 key schedule: replays round keys last-first from the final round key.
// Latency: round ROUND_COUNT visible the cycle after start; one further round per accepted cycle.
// Backpressure: key_ready low freezes key, index and state; start is ignored while busy.

package aes_model_pack;
  localparam int ROUND_COUNT = 10;
  // 16 bytes, byte 15 is the most significant (first byte of word 0)
  typedef logic [15:0][7:0] byte_table;
endpackage

module key_unwarm #(
  parameter int ROUND_COUNT = aes_model_pack::ROUND_COUNT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  aes_model_pack::byte_table last_key,
  input  logic                      start,
  input  logic                      key_ready,
  output logic [127:0]              round_key,
  output logic [3:0]                round_idx,
  output logic                      key_valid,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [0:0] {
    IDLE,
    EMIT
  } state_t;

  // Forward AES S-box, entry 0 first
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constant that was mixed in when round r was produced going forward
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  state_t       state;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot_p3;
  logic [127:0] prev_key;
  logic         accept;

  assign accept = key_valid & key_ready;

  // Undo one forward expansion round: the three xor-chained words first, then word 0 via p3
  always_comb begin
    w0       = round_key[127:96];
    w1       = round_key[95:64];
    w2       = round_key[63:32];
    w3       = round_key[31:0];
    p3       = w3 ^ w2;
    p2       = w2 ^ w1;
    p1       = w1 ^ w0;
    rot_p3   = {p3[23:0], p3[31:24]};
    p0       = w0 ^ sub_word(rot_p3) ^ {rcon(round_idx), 24'h0};
    prev_key = {p0, p1, p2, p3};
  end

  // Sequencer: load on start, step down one round per accepted key, pulse done after round 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      round_key <= '0;
      round_idx <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            round_key <= last_key;
            round_idx <= 4'(ROUND_COUNT);
            key_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (accept) begin
            if (round_idx != 4'd0) begin
              round_key <= prev_key;
              round_idx <= round_idx - 4'd1;
            end else begin
              done      <= 1'b1;
              key_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          key_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_unwarm.sv
// Bench for key_unwarm: known-answer table, random backpressure, round trips, corner sequences.
// Reference: forward AES key expansion with an S-box derived from GF(2^8) inversion.
// Outputs sampled on the falling edge; inputs driven right after sampling.

module tb_key_unwarm;

  localparam int ROUNDS = 10;

  logic                      clk;
  logic                      rst;
  aes_model_pack::byte_table last_key;
  logic                      start;
  logic                      key_ready;
  logic [127:0]              round_key;
  logic [3:0]                round_idx;
  logic                      key_valid;
  logic                      busy;
  logic                      done;

  key_unwarm dut (
    .clk       (clk),
    .rst       (rst),
    .last_key  (last_key),
    .start     (start),
    .key_ready (key_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } vec_t;

  int           total = 0;
  int           bad   = 0;
  logic [7:0]   sb  [256];
  logic [127:0] rk  [ROUNDS+1];
  logic [127:0] obs [ROUNDS+1];
  vec_t         tab [4];

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: DUT did not reach the expected event", name);
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box = affine transform of the multiplicative inverse in GF(2^8)
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Forward FIPS-197 key expansion into rk[0..10]
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= ROUNDS; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic launch(input logic [127:0] lk, input bit hold);
    @(negedge clk);
    last_key  = lk;
    start     = 1'b1;
    key_ready = 1'b0;
    @(negedge clk);
    start = hold;
  endtask

  // Entered at the first falling edge after the loading edge; returns at the falling edge showing done
  task automatic collect(input int pct, input bit poke, input bit hold);
    int           exp_idx = ROUNDS;
    int           acc     = 0;
    bit           stalled = 1'b0;
    bit           fin     = 1'b0;
    bit           ready;
    logic [127:0] h_key;
    logic [3:0]   h_idx;
    check("first_valid", 128'(key_valid), 128'd1);
    check("first_idx", 128'(round_idx), 128'(ROUNDS));
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done) begin
        fin = 1'b1;
        check("done_busy", 128'(busy), 128'd0);
        check("done_valid", 128'(key_valid), 128'd0);
        check("accept_count", 128'(acc), 128'(ROUNDS + 1));
        break;
      end
      if (!key_valid) begin
        check("valid_gap", 128'(key_valid), 128'd1);
        break;
      end
      if (exp_idx < 0) begin
        fail_now("no_done_after_idx0");
        break;
      end
      if (stalled) begin
        check("stall_key", round_key, h_key);
        check("stall_idx", 128'(round_idx), 128'(h_idx));
      end
      check("busy_emit", 128'(busy), 128'd1);
      check("idx", 128'(round_idx), 128'(exp_idx));
      check("key", round_key, rk[exp_idx]);
      ready = ($urandom_range(99) < pct);
      if (ready) begin
        obs[exp_idx] = round_key;
        acc++;
        exp_idx--;
      end
      key_ready = ready;
      if (poke) begin
        start    = 1'($urandom_range(1));
        last_key = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start = hold;
      end
      stalled = !ready;
      h_key   = round_key;
      h_idx   = round_idx;
      @(negedge clk);
    end
    key_ready = 1'b0;
    start     = hold;
    if (!fin) fail_now("sequence_end");
  endtask

  task automatic after_done();
    @(negedge clk);
    check("done_once", 128'(done), 128'd0);
    check("idle_valid", 128'(key_valid), 128'd0);
    check("idle_busy", 128'(busy), 128'd0);
    check("idle_key_hold", round_key, rk[0]);
    check("idle_idx_hold", 128'(round_idx), 128'd0);
  endtask

  task automatic run(input logic [127:0] orig, input int pct, input bit poke);
    expand(orig);
    launch(rk[ROUNDS], 1'b0);
    collect(pct, poke, 1'b0);
    after_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] orig;

    tab[0] = '{idx: 4'd10, key: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tab[1] = '{idx: 4'd9,  key: 128'hac7766f319fadc2128d12941575c006e};
    tab[2] = '{idx: 4'd1,  key: 128'ha0fafe1788542cb123a339392a6c7605};
    tab[3] = '{idx: 4'd0,  key: 128'h2b7e151628aed2a6abf7158809cf4f3c};

    rst       = 1'b1;
    start     = 1'b0;
    key_ready = 1'b0;
    last_key  = '0;
    build_sbox();

    repeat (2) @(negedge clk);
    check("rst_key", round_key, 128'd0);
    check("rst_idx", 128'(round_idx), 128'd0);
    check("rst_valid", 128'(key_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    rst = 1'b0;

    // Known-answer sequence, consumer always ready
    expand(FIPS_KEY);
    launch(FIPS_LAST, 1'b0);
    collect(100, 1'b0, 1'b0);
    after_done();
    for (int i = 0; i < 4; i++) check($sformatf("kat_idx%0d", tab[i].idx), obs[tab[i].idx], tab[i].key);

    // Same sequence under 50% backpressure
    for (int i = 0; i <= ROUNDS; i++) obs[i] = '0;
    expand(FIPS_KEY);
    launch(FIPS_LAST, 1'b0);
    collect(50, 1'b0, 1'b0);
    after_done();
    for (int i = 0; i < 4; i++) check($sformatf("bp_idx%0d", tab[i].idx), obs[tab[i].idx], tab[i].key);

    // start and last_key toggled while emitting must not disturb the sequence
    run(FIPS_KEY, 60, 1'b1);

    // Asynchronous reset in the middle of a sequence
    expand(FIPS_KEY);
    launch(FIPS_LAST, 1'b0);
    key_ready = 1'b1;
    for (int c = 0; c < 20 && round_idx != 4'd5; c++) @(negedge clk);
    check("reach_idx5", 128'(round_idx), 128'd5);
    #2 rst = 1'b1;
    #1;
    check("arst_key", round_key, 128'd0);
    check("arst_idx", 128'(round_idx), 128'd0);
    check("arst_valid", 128'(key_valid), 128'd0);
    check("arst_busy", 128'(busy), 128'd0);
    check("arst_done", 128'(done), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    key_ready = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 128'(key_valid), 128'd0);
    check("post_rst_busy", 128'(busy), 128'd0);
    run(FIPS_KEY, 100, 1'b0);

    // start held through done: next sequence follows after one idle cycle with a fresh key
    expand(FIPS_KEY);
    launch(FIPS_LAST, 1'b1);
    collect(100, 1'b0, 1'b1);
    orig = {$urandom, $urandom, $urandom, $urandom};
    expand(orig);
    last_key = rk[ROUNDS];
    @(negedge clk);
    start = 1'b0;
    collect(100, 1'b0, 1'b0);
    after_done();
    check("b2b_idx0", obs[0], orig);

    // Round trip of random keys through the forward schedule and back
    for (int k = 0; k < 100; k++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      run(orig, 70, 1'b0);
      check("roundtrip_idx0", obs[0], orig);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
